// File: rtl/fxp_pkg.sv
// Q8.24 fixed-point constants and helpers shared by the tanh forward and backward units.
package fxp_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned FRAC  = 24;

  typedef logic signed [WIDTH-1:0]   fxp_t;
  typedef logic signed [2*WIDTH-1:0] fxp_wide_t;

  localparam fxp_t ONE     = 32'h01000000;
  localparam fxp_t NEG_ONE = 32'hFF000000;

  // Q8.24 result of a full-width product: drop FRAC low bits, keep WIDTH bits.
  function automatic fxp_t q_slice(input fxp_wide_t p);
    return p[WIDTH+FRAC-1:FRAC];
  endfunction

endpackage

// File: rtl/tanh_backprop_if.sv
// Sample-in / gradient-out stream bundle for the tanh backward unit.
interface tanh_backprop_if;
  import fxp_pkg::*;

  logic i_valid;
  logic i_ready;
  fxp_t i_y;
  fxp_t i_g;
  logic i_last;
  logic o_valid;
  logic o_ready;
  fxp_t o_d;
  logic o_last;

  // Unit side: consumes samples, produces gradients.
  modport slave (
    input  i_valid, i_y, i_g, i_last, o_ready,
    output i_ready, o_valid, o_d, o_last
  );

  // Environment side: produces samples, consumes gradients.
  modport master (
    output i_valid, i_y, i_g, i_last, o_ready,
    input  i_ready, o_valid, o_d, o_last
  );

endinterface

// File: rtl/fxp_mul.sv
// Combinational signed Q8.24 multiply returning the Q8.24 slice (floor rounding).
module fxp_mul
  import fxp_pkg::*;
(
  input  fxp_t a,
  input  fxp_t b,
  output fxp_t p
);

  fxp_wide_t prod;

  // Full 64-bit signed product, then floor slice back to Q8.24.
  always_comb begin
    prod = fxp_wide_t'(a) * fxp_wide_t'(b);
    p    = q_slice(prod);
  end

endmodule

// File: rtl/tanh_backprop.sv
// Backward pass of piecewise-linear tanh: d = g * (1 - y^2), 3-stage pipeline
// with a single global enable so a stalled output freezes every stage.
module tanh_backprop
  import fxp_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  tanh_backprop_if.slave  bus
);

  logic             en;
  logic [WIDTH-1:0] y_abs;
  fxp_t             yc;
  fxp_t             sq_prod;
  fxp_t             d_prod;

  // Stage 1
  logic v1_q, v1_d;
  fxp_t g1_q, g1_d;
  logic l1_q, l1_d;
  fxp_t sq_q, sq_d;
  // Stage 2
  logic v2_q, v2_d;
  fxp_t g2_q, g2_d;
  logic l2_q, l2_d;
  fxp_t f_q,  f_d;
  // Stage 3 (output)
  logic ov_q, ov_d;
  fxp_t od_q, od_d;
  logic ol_q, ol_d;

  // Clamp |y| to 1.0; the most-negative input negates to itself, which
  // compares above ONE as unsigned and so also clamps to 1.0.
  always_comb begin
    y_abs = bus.i_y[WIDTH-1] ? (~bus.i_y + 32'd1) : bus.i_y;
    yc    = (y_abs > ONE) ? ONE : fxp_t'(y_abs);
  end

  fxp_mul u_sq (
    .a (yc),
    .b (yc),
    .p (sq_prod)
  );

  fxp_mul u_prod (
    .a (g2_q),
    .b (f_q),
    .p (d_prod)
  );

  // Next-state for every pipeline register; everything holds unless enabled.
  always_comb begin
    en   = ~ov_q | bus.o_ready;
    v1_d = v1_q;
    g1_d = g1_q;
    l1_d = l1_q;
    sq_d = sq_q;
    v2_d = v2_q;
    g2_d = g2_q;
    l2_d = l2_q;
    f_d  = f_q;
    ov_d = ov_q;
    od_d = od_q;
    ol_d = ol_q;
    if (en) begin
      v1_d = bus.i_valid;
      g1_d = bus.i_g;
      l1_d = bus.i_last;
      sq_d = sq_prod;
      v2_d = v1_q;
      g2_d = g1_q;
      l2_d = l1_q;
      f_d  = ONE - sq_q;
      ov_d = v2_q;
      od_d = d_prod;
      ol_d = l2_q;
    end
  end

  // Pipeline registers; reset flushes all in-flight samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      g1_q <= '0;
      l1_q <= 1'b0;
      sq_q <= '0;
      v2_q <= 1'b0;
      g2_q <= '0;
      l2_q <= 1'b0;
      f_q  <= '0;
      ov_q <= 1'b0;
      od_q <= '0;
      ol_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      g1_q <= g1_d;
      l1_q <= l1_d;
      sq_q <= sq_d;
      v2_q <= v2_d;
      g2_q <= g2_d;
      l2_q <= l2_d;
      f_q  <= f_d;
      ov_q <= ov_d;
      od_q <= od_d;
      ol_q <= ol_d;
    end
  end

  assign bus.i_ready = en;
  assign bus.o_valid = ov_q;
  assign bus.o_d     = od_q;
  assign bus.o_last  = ol_q;

endmodule

// File: tb/tb_tanh_backprop.sv
// Self-checking bench for tanh_backprop against an integer reference of g*(1-y^2).
module tb_tanh_backprop;
  import fxp_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [32:0] exp_q[$];
  logic [32:0] obs_q[$];

  tanh_backprop_if bus();

  tanh_backprop dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: clamp |y|, square, subtract from one, scale g, all floor-shifted.
  function automatic logic [31:0] ref_d(input logic [31:0] y, input logic [31:0] g);
    longint ya, yc, sq, f, d;
    ya = longint'($signed(y));
    if (ya < 0) ya = -ya;
    yc = (ya > 64'sd16777216) ? 64'sd16777216 : ya;
    sq = (yc * yc) >>> 24;
    f  = 64'sd16777216 - sq;
    d  = (longint'($signed(g)) * f) >>> 24;
    return d[31:0];
  endfunction

  // One clock: record handshakes that will fire on the coming edge, then advance.
  task automatic tick();
    #1;
    if (bus.i_valid && bus.i_ready)
      exp_q.push_back({bus.i_last, ref_d(bus.i_y, bus.i_g)});
    if (bus.o_valid && bus.o_ready)
      obs_q.push_back({bus.o_last, bus.o_d});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] y, input logic [31:0] g, input logic last);
    logic acc;
    bus.i_valid = 1'b1;
    bus.i_y     = y;
    bus.i_g     = g;
    bus.i_last  = last;
    for (int n = 0; n < 20; n++) begin
      #1;
      acc = bus.i_ready;
      tick();
      if (acc) break;
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic drain();
    bus.o_ready = 1'b1;
    bus.i_valid = 1'b0;
    for (int n = 0; n < 50 && obs_q.size() < exp_q.size(); n++) tick();
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid got %b want 0", bus.o_valid); end
    checks++; if (bus.o_d !== 32'h0) begin errors++; $display("FAIL reset_o_d got %h want 00000000", bus.o_d); end
    checks++; if (bus.o_last !== 1'b0) begin errors++; $display("FAIL reset_o_last got %b want 0", bus.o_last); end
    checks++; if (bus.i_ready !== 1'b1) begin errors++; $display("FAIL reset_i_ready got %b want 1", bus.i_ready); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    exp_q.delete(); obs_q.delete();
    bus.o_ready = 1'b1;
    bus.i_valid = 1'b1; bus.i_y = 32'h0; bus.i_g = 32'h01000000; bus.i_last = 1'b0;
    #1;
    checks++; if (bus.i_ready !== 1'b1) begin errors++; $display("FAIL basic_i_ready got %b want 1", bus.i_ready); end
    tick();
    bus.i_valid = 1'b0;
    lat = 1;
    while (!bus.o_valid && lat < 10) begin tick(); lat++; end
    checks++; if (lat != 3) begin errors++; $display("FAIL basic_latency got %0d want 3", lat); end
    checks++; if (bus.o_d !== 32'h01000000) begin errors++; $display("FAIL basic_o_d got %h want 01000000", bus.o_d); end
    tick();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL basic_single got o_valid %b want 0", bus.o_valid); end
  endtask

  task automatic test_mid();
    exp_q.delete(); obs_q.delete();
    bus.o_ready = 1'b1;
    send(32'h00800000, 32'h01000000, 1'b0);
    send(32'hFF800000, 32'hFE000000, 1'b1);
    drain();
    checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL mid_count got %0d want 2", obs_q.size()); end
    else begin
      checks++; if (obs_q[0] !== {1'b0, 32'h00C00000}) begin errors++; $display("FAIL mid_pos got %h want 000C00000", obs_q[0]); end
      checks++; if (obs_q[1] !== {1'b1, 32'hFE800000}) begin errors++; $display("FAIL mid_neg got %h want 1FE800000", obs_q[1]); end
    end
  endtask

  task automatic test_clamp();
    logic [31:0] ys [3];
    ys[0] = 32'h01000000; ys[1] = 32'h01800000; ys[2] = 32'h80000000;
    exp_q.delete(); obs_q.delete();
    bus.o_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(ys[i], 32'h7FFFFFFF, 1'b0);
    drain();
    checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL clamp_count got %0d want 3", obs_q.size()); end
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== 33'h0) begin errors++; $display("FAIL clamp_%0d y=%h got %h want 000000000", i, ys[i], obs_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    int k;
    logic acc;
    logic [31:0] held;
    exp_q.delete(); obs_q.delete();
    k = 1;
    held = '0;
    for (int c = 0; c < 60 && obs_q.size() < 8; c++) begin
      bus.o_ready = !(c >= 4 && c < 9);
      if (k <= 8) begin
        bus.i_valid = 1'b1; bus.i_y = 32'h0; bus.i_g = 32'(k) << 24; bus.i_last = (k == 8);
      end else begin
        bus.i_valid = 1'b0;
      end
      #1;
      if (c >= 4 && c < 9) begin
        checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL bp_stall_valid c=%0d got %b want 1", c, bus.o_valid); end
        checks++; if (bus.i_ready !== 1'b0) begin errors++; $display("FAIL bp_i_ready c=%0d got %b want 0", c, bus.i_ready); end
        if (c == 4) held = bus.o_d;
        else begin
          checks++; if (bus.o_d !== held) begin errors++; $display("FAIL bp_stable c=%0d got %h want %h", c, bus.o_d, held); end
        end
      end
      acc = bus.i_valid && bus.i_ready;
      tick();
      if (acc) k++;
    end
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b1;
    checks++; if (obs_q.size() != 8) begin errors++; $display("FAIL bp_count got %0d want 8", obs_q.size()); end
    for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== {(i == 7), 32'(i + 1) << 24})
        begin errors++; $display("FAIL bp_out_%0d got %h want %h", i, obs_q[i], {(i == 7), 32'(i + 1) << 24}); end
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    exp_q.delete(); obs_q.delete();
    bus.o_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.i_valid = 1'b1; bus.i_y = 32'h0; bus.i_g = 32'h05000000; bus.i_last = 1'b1;
      tick();
    end
    bus.i_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL rstmid_o_valid got %b want 0", bus.o_valid); end
    checks++; if (bus.o_d !== 32'h0) begin errors++; $display("FAIL rstmid_o_d got %h want 00000000", bus.o_d); end
    checks++; if (bus.o_last !== 1'b0) begin errors++; $display("FAIL rstmid_o_last got %b want 0", bus.o_last); end
    exp_q.delete(); obs_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rstmid_stale got %0d outputs want 0", obs_q.size()); end
    bus.i_valid = 1'b1; bus.i_y = 32'h00800000; bus.i_g = 32'h01000000; bus.i_last = 1'b0;
    tick();
    bus.i_valid = 1'b0;
    lat = 1;
    while (!bus.o_valid && lat < 10) begin tick(); lat++; end
    checks++; if (lat != 3) begin errors++; $display("FAIL rstmid_latency got %0d want 3", lat); end
    checks++; if (bus.o_d !== 32'h00C00000) begin errors++; $display("FAIL rstmid_o_d got %h want 00C00000", bus.o_d); end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] mag;
    exp_q.delete(); obs_q.delete();
    for (int c = 0; c < 60000 && exp_q.size() < 10000; c++) begin
      bus.o_ready = ($urandom_range(0, 3) != 0);
      bus.i_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) bus.i_y = $urandom;
      else begin
        mag = $urandom_range(0, 32'h01000000);
        bus.i_y = $urandom_range(0, 1) ? (~mag + 32'd1) : mag;
      end
      bus.i_g    = $urandom;
      bus.i_last = $urandom_range(0, 1);
      tick();
    end
    drain();
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_y     = '0;
    bus.i_g     = '0;
    bus.i_last  = 1'b0;
    bus.o_ready = 1'b1;
    test_reset();
    test_basic();
    test_mid();
    test_clamp();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
